// File: rtl/adder_regfile_mc.sv
// adder_regfile_mc
//   Register file between the AMBA-style slave channels and the adder datapath.
//   It holds NUM_OPS operand registers, CTRL, STATUS and RESULT, and runs the
//   start/done handshake with the datapath.
//
// Ports
//   ACLK, ARST        clock, synchronous active-high reset
//   i_addr_wc/i_data_wc/i_strb_wc/i_en_amba_write
//                     write channel (word index, data, byte strobes, enable)
//   i_addr_rc         read word index
//   o_data_rc         registered read data (1-cycle latency)
//   o_start           one-cycle start pulse to the datapath
//   i_done/i_busr/i_carry
//                     datapath completion, result and carry-out
//   o_ops             operand registers, op0 in the LSBs
//   o_busy            operation in flight
//   o_irq             DONE & IRQ_EN
//
// Register map (word index)
//   0 CTRL   : [0] START (write-1 pulse, reads 0), [1] IRQ_EN
//   1 STATUS : [0] BUSY (RO), [1] DONE, [2] CARRY, [3] ERR (W1C)
//   2 RESULT : read-only
//   3..      : OP0..OP(NUM_OPS-1)
module adder_regfile_mc #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int NUM_OPS = 2
) (
   input  logic                      ACLK,
   input  logic                      ARST,
   input  logic [ADDR_W-1:0]         i_addr_wc,
   input  logic [DATA_W-1:0]         i_data_wc,
   input  logic [DATA_W/8-1:0]       i_strb_wc,
   input  logic                      i_en_amba_write,
   input  logic [ADDR_W-1:0]         i_addr_rc,
   output logic [DATA_W-1:0]         o_data_rc,
   output logic                      o_start,
   input  logic                      i_done,
   input  logic [DATA_W-1:0]         i_busr,
   input  logic                      i_carry,
   output logic [NUM_OPS*DATA_W-1:0] o_ops,
   output logic                      o_busy,
   output logic                      o_irq
);

   localparam int NB       = DATA_W / 8;
   localparam int OP_BASE  = 3;

   logic [NUM_OPS-1:0][DATA_W-1:0] ops_q, ops_d;
   logic [DATA_W-1:0]              result_q, result_d;
   logic [DATA_W-1:0]              rdata_q, rdata_d;
   logic                           irq_en_q, irq_en_d;
   logic                           busy_q, busy_d;
   logic                           done_q, done_d;
   logic                           carry_q, carry_d;
   logic                           err_q, err_d;
   logic                           start_q, start_d;

   logic                           wr_ctrl;
   logic                           wr_stat;

   // Control/status bits only respond to byte lane 0.
   assign wr_ctrl = i_en_amba_write && (i_addr_wc == ADDR_W'(0)) && i_strb_wc[0];
   assign wr_stat = i_en_amba_write && (i_addr_wc == ADDR_W'(1)) && i_strb_wc[0];

   // Next-state logic. Ordering matters: W1C clears are applied first so that
   // a same-cycle set (done capture, start error) overrides them.
   always_comb begin
      ops_d    = ops_q;
      result_d = result_q;
      irq_en_d = irq_en_q;
      busy_d   = busy_q;
      done_d   = done_q;
      carry_d  = carry_q;
      err_d    = err_q;
      start_d  = 1'b0;

      if (wr_stat) begin
         if (i_data_wc[1]) done_d  = 1'b0;
         if (i_data_wc[2]) carry_d = 1'b0;
         if (i_data_wc[3]) err_d   = 1'b0;
      end

      if (wr_ctrl) irq_en_d = i_data_wc[1];

      if (busy_q && i_done) begin
         result_d = i_busr;
         carry_d  = i_carry;
         done_d   = 1'b1;
         busy_d   = 1'b0;
      end

      // START is judged against the registered state, so a START coinciding
      // with i_done is still an error.
      if (wr_ctrl && i_data_wc[0]) begin
         if (busy_q) begin
            err_d = 1'b1;
         end else begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            carry_d = 1'b0;
            err_d   = 1'b0;
         end
      end

      // Operands are frozen while an operation is in flight.
      for (int k = 0; k < NUM_OPS; k++) begin
         if (i_en_amba_write && (i_addr_wc == ADDR_W'(k + OP_BASE))) begin
            if (busy_q) begin
               err_d = 1'b1;
            end else begin
               for (int b = 0; b < NB; b++) begin
                  if (i_strb_wc[b]) ops_d[k][8*b +: 8] = i_data_wc[8*b +: 8];
               end
            end
         end
      end
   end

   // Read mux works on registered state, giving pre-write data on collisions.
   always_comb begin
      rdata_d = '0;
      if (i_addr_rc == ADDR_W'(0)) begin
         rdata_d[1] = irq_en_q;
      end else if (i_addr_rc == ADDR_W'(1)) begin
         rdata_d[3:0] = {err_q, carry_q, done_q, busy_q};
      end else if (i_addr_rc == ADDR_W'(2)) begin
         rdata_d = result_q;
      end else begin
         for (int k = 0; k < NUM_OPS; k++) begin
            if (i_addr_rc == ADDR_W'(k + OP_BASE)) rdata_d = ops_q[k];
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         ops_q    <= '0;
         result_q <= '0;
         rdata_q  <= '0;
         irq_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         ops_q    <= ops_d;
         result_q <= result_d;
         rdata_q  <= rdata_d;
         irq_en_q <= irq_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
         start_q  <= start_d;
      end
   end

   assign o_data_rc = rdata_q;
   assign o_start   = start_q;
   assign o_busy    = busy_q;
   assign o_ops     = ops_q;
   assign o_irq     = done_q & irq_en_q;

endmodule

// File: tb/tb_adder_regfile_mc.sv
module tb_adder_regfile_mc;

   logic        ACLK = 1'b0;
   logic        ARST;
   logic [31:0] i_addr_wc, i_data_wc, i_addr_rc, o_data_rc, i_busr;
   logic [3:0]  i_strb_wc;
   logic        i_en_amba_write, o_start, i_done, i_carry, o_busy, o_irq;
   logic [63:0] o_ops;

   int total = 0;
   int bad   = 0;

   adder_regfile_mc #(.DATA_W(32), .ADDR_W(32), .NUM_OPS(2)) dut (
      .ACLK(ACLK), .ARST(ARST),
      .i_addr_wc(i_addr_wc), .i_data_wc(i_data_wc), .i_strb_wc(i_strb_wc),
      .i_en_amba_write(i_en_amba_write), .i_addr_rc(i_addr_rc), .o_data_rc(o_data_rc),
      .o_start(o_start), .i_done(i_done), .i_busr(i_busr), .i_carry(i_carry),
      .o_ops(o_ops), .o_busy(o_busy), .o_irq(o_irq)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      bit          wr;
      int unsigned wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      bit          dn;
      logic [31:0] br;
      bit          cy;
      int unsigned ra;
      logic [31:0] e_rd;
      bit          e_st;
      bit          e_bz;
      bit          e_irq;
   } row_t;

   row_t tbl[32];

   // Reference model: architectural state of the register file.
   bit          m_irq_en, m_busy, m_done, m_carry, m_err;
   logic [31:0] m_res;
   logic [31:0] m_ops[2];

   function automatic row_t mk(bit wr, int unsigned wa, logic [31:0] wd, logic [3:0] ws,
                               bit dn, logic [31:0] br, bit cy, int unsigned ra,
                               logic [31:0] e_rd, bit e_st, bit e_bz, bit e_irq);
      row_t r;
      r.wr = wr; r.wa = wa; r.wd = wd; r.ws = ws; r.dn = dn; r.br = br; r.cy = cy;
      r.ra = ra; r.e_rd = e_rd; r.e_st = e_st; r.e_bz = e_bz; r.e_irq = e_irq;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, let the rising edge happen, return
   // at the next falling edge so outputs are stable for sampling.
   task automatic drv(input bit rst, input bit wr, input int unsigned wa, input logic [31:0] wd,
                      input logic [3:0] ws, input bit dn, input logic [31:0] br, input bit cy,
                      input int unsigned ra);
      ARST = rst; i_en_amba_write = wr; i_addr_wc = wa; i_data_wc = wd; i_strb_wc = ws;
      i_done = dn; i_busr = br; i_carry = cy; i_addr_rc = ra;
      @(posedge ACLK);
      @(negedge ACLK);
   endtask

   function automatic logic [31:0] m_read(int unsigned a);
      case (a)
         0: return m_irq_en ? 32'h2 : 32'h0;
         1: return 32'(m_busy) | (32'(m_done) << 1) | (32'(m_carry) << 2) | (32'(m_err) << 3);
         2: return m_res;
         3: return m_ops[0];
         4: return m_ops[1];
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_clear();
      m_irq_en = 0; m_busy = 0; m_done = 0; m_carry = 0; m_err = 0;
      m_res = 0; m_ops[0] = 0; m_ops[1] = 0;
   endtask

   // One clock of transaction-level behaviour.
   task automatic m_step(input bit rst, input bit wr, input int unsigned wa, input logic [31:0] wd,
                         input logic [3:0] ws, input bit dn, input logic [31:0] br, input bit cy,
                         input int unsigned ra, output logic [31:0] e_rd, output bit e_st);
      bit          was_busy;
      logic [31:0] mask;
      e_rd = m_read(ra);
      e_st = 0;
      if (rst) begin
         m_clear();
         e_rd = 0;
         return;
      end
      was_busy = m_busy;
      if (wr && wa == 1 && ws[0]) begin
         if (wd[1]) m_done  = 0;
         if (wd[2]) m_carry = 0;
         if (wd[3]) m_err   = 0;
      end
      if (wr && wa == 0 && ws[0]) m_irq_en = wd[1];
      if (was_busy && dn) begin
         m_res = br; m_carry = cy; m_done = 1; m_busy = 0;
      end
      if (wr && wa == 0 && ws[0] && wd[0]) begin
         if (was_busy) m_err = 1;
         else begin
            e_st = 1; m_busy = 1; m_done = 0; m_carry = 0; m_err = 0;
         end
      end
      if (wr && (wa == 3 || wa == 4)) begin
         if (was_busy) m_err = 1;
         else begin
            mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
            m_ops[wa-3] = (m_ops[wa-3] & ~mask) | (wd & mask);
         end
      end
   endtask

   initial begin
      logic [31:0] e_rd;
      bit          e_st;
      bit          rst, wr, dn, cy;
      int unsigned wa, ra;
      logic [31:0] wd, br;
      logic [3:0]  ws;

      ARST = 1; i_en_amba_write = 0; i_addr_wc = 0; i_data_wc = 0; i_strb_wc = 0;
      i_done = 0; i_busr = 0; i_carry = 0; i_addr_rc = 0;
      @(negedge ACLK);

      // Reset with writes active.
      drv(1, 1, 0, 32'h3, 4'hF, 0, 0, 0, 0);
      drv(1, 1, 3, 32'hFFFF_FFFF, 4'hF, 1, 32'h55, 1, 3);
      chk("rst_start", o_start, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_irq", o_irq, 0);
      chk("rst_rdata", o_data_rc, 0);
      chk("rst_ops", o_ops, 0);
      for (int i = 0; i < 5; i++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 0, i);
         chk($sformatf("rst_read%0d", i), o_data_rc, 0);
      end

      //          wr wa wd             ws    dn br     cy ra  e_rd           st bz irq
      tbl[0]  = mk(1, 3, 32'h5,        4'hF, 0, 0,     0, 3, 32'h0,         0, 0, 0);
      tbl[1]  = mk(1, 4, 32'h3,        4'hF, 0, 0,     0, 3, 32'h5,         0, 0, 0);
      tbl[2]  = mk(1, 0, 32'h1,        4'hF, 0, 0,     0, 4, 32'h3,         1, 1, 0);
      tbl[3]  = mk(0, 0, 0,            4'h0, 0, 0,     0, 1, 32'h1,         0, 1, 0);
      tbl[4]  = mk(0, 0, 0,            4'h0, 0, 0,     0, 0, 32'h0,         0, 1, 0);
      tbl[5]  = mk(0, 0, 0,            4'h0, 1, 32'h8, 0, 1, 32'h1,         0, 0, 0);
      tbl[6]  = mk(0, 0, 0,            4'h0, 0, 0,     0, 2, 32'h8,         0, 0, 0);
      tbl[7]  = mk(0, 0, 0,            4'h0, 0, 0,     0, 1, 32'h2,         0, 0, 0);
      tbl[8]  = mk(1, 3, 32'hFFFF_FFFF,4'hF, 0, 0,     0, 3, 32'h5,         0, 0, 0);
      tbl[9]  = mk(1, 3, 32'h1234_5678,4'h5, 0, 0,     0, 3, 32'hFFFF_FFFF, 0, 0, 0);
      tbl[10] = mk(0, 0, 0,            4'h0, 0, 0,     0, 3, 32'hFF34_FF78, 0, 0, 0);
      tbl[11] = mk(1, 0, 32'h1,        4'hF, 0, 0,     0, 1, 32'h2,         1, 1, 0);
      tbl[12] = mk(1, 4, 32'hDEAD,     4'hF, 0, 0,     0, 1, 32'h1,         0, 1, 0);
      tbl[13] = mk(1, 0, 32'h1,        4'hF, 0, 0,     0, 1, 32'h9,         0, 1, 0);
      tbl[14] = mk(0, 0, 0,            4'h0, 0, 0,     0, 4, 32'h3,         0, 1, 0);
      tbl[15] = mk(1, 1, 32'h8,        4'h1, 0, 0,     0, 1, 32'h9,         0, 1, 0);
      tbl[16] = mk(0, 0, 0,            4'h0, 0, 0,     0, 1, 32'h1,         0, 1, 0);
      tbl[17] = mk(0, 0, 0,            4'h0, 1, 32'h11,0, 1, 32'h1,         0, 0, 0);
      tbl[18] = mk(1, 1, 32'h2,        4'h1, 0, 0,     0, 1, 32'h2,         0, 0, 0);
      tbl[19] = mk(1, 0, 32'h2,        4'h1, 0, 0,     0, 1, 32'h0,         0, 0, 0);
      tbl[20] = mk(1, 0, 32'h3,        4'h1, 0, 0,     0, 0, 32'h2,         1, 1, 0);
      tbl[21] = mk(0, 0, 0,            4'h0, 0, 0,     0, 0, 32'h2,         0, 1, 0);
      tbl[22] = mk(0, 0, 0,            4'h0, 1, 32'h0, 1, 2, 32'h11,        0, 0, 1);
      tbl[23] = mk(0, 0, 0,            4'h0, 0, 0,     0, 1, 32'h6,         0, 0, 1);
      tbl[24] = mk(1, 1, 32'h2,        4'h1, 0, 0,     0, 2, 32'h0,         0, 0, 0);
      tbl[25] = mk(0, 0, 0,            4'h0, 0, 0,     0, 1, 32'h4,         0, 0, 0);
      tbl[26] = mk(1, 0, 32'h3,        4'h1, 0, 0,     0, 1, 32'h4,         1, 1, 0);
      tbl[27] = mk(1, 1, 32'h2,        4'h1, 1, 32'h77,0, 1, 32'h1,         0, 0, 1);
      tbl[28] = mk(0, 0, 0,            4'h0, 0, 0,     0, 1, 32'h2,         0, 0, 1);
      tbl[29] = mk(1, 0, 32'h1,        4'hE, 0, 0,     0, 2, 32'h77,        0, 0, 1);
      tbl[30] = mk(1, 2, 32'hAAAA,     4'hF, 0, 0,     0, 5, 32'h0,         0, 0, 1);
      tbl[31] = mk(0, 0, 0,            4'h0, 0, 0,     0, 2, 32'h77,        0, 0, 1);

      foreach (tbl[i]) begin
         drv(0, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].ws, tbl[i].dn, tbl[i].br, tbl[i].cy, tbl[i].ra);
         chk($sformatf("v%0d_rdata", i), o_data_rc, tbl[i].e_rd);
         chk($sformatf("v%0d_start", i), o_start, tbl[i].e_st);
         chk($sformatf("v%0d_busy", i), o_busy, tbl[i].e_bz);
         chk($sformatf("v%0d_irq", i), o_irq, tbl[i].e_irq);
      end

      // Reset mid-operation: later i_done must be ignored.
      drv(0, 1, 0, 32'h1, 4'h1, 0, 0, 0, 2);
      chk("mid_busy_set", o_busy, 1);
      drv(1, 0, 0, 0, 0, 0, 0, 0, 2);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_irq", o_irq, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h99, 1, 2);
      chk("mid_done_busy", o_busy, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 2);
      chk("mid_result", o_data_rc, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("mid_status", o_data_rc, 0);

      // Randomized traffic against the reference model.
      m_clear();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         wr  = $urandom_range(0, 1);
         wa  = $urandom_range(0, 6);
         wd  = $urandom();
         ws  = 4'($urandom());
         dn  = m_busy && ($urandom_range(0, 2) == 0);
         br  = $urandom();
         cy  = $urandom_range(0, 1);
         ra  = $urandom_range(0, 6);
         m_step(rst, wr, wa, wd, ws, dn, br, cy, ra, e_rd, e_st);
         drv(rst, wr, wa, wd, ws, dn, br, cy, ra);
         chk($sformatf("r%0d_rdata", n), o_data_rc, e_rd);
         chk($sformatf("r%0d_start", n), o_start, e_st);
         chk($sformatf("r%0d_busy", n), o_busy, m_busy);
         chk($sformatf("r%0d_irq", n), o_irq, m_done & m_irq_en);
         chk($sformatf("r%0d_ops", n), o_ops, {m_ops[1], m_ops[0]});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adder_regfile_mc.md
Name: adder_regfile_mc

Overview:
Parametrised successor of the adder AMBA register file. It holds NUM_OPS operand registers of DATA_W bits, a control register, a status register and a result register, all behind the simple AMBA-style write/read channels. It drives a start/done handshake to the adder datapath, captures the result and carry, tracks busy/done/error status and raises an interrupt. It sits between the AMBA slave interface logic and the adder datapath.

Parameters:
DATA_W, 32, data/register width in bits; must be a multiple of 8.
ADDR_W, 32, width of the word-index address buses.
NUM_OPS, 2, number of operand registers; legal range 2..8.

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARST  in  1  synchronous active-high reset.
i_addr_wc  in  ADDR_W  write word index.
i_data_wc  in  DATA_W  write data.
i_strb_wc  in  DATA_W/8  byte write strobes.
i_en_amba_write  in  1  write enable; qualifies addr/data/strb for one cycle.
i_addr_rc  in  ADDR_W  read word index.
o_data_rc  out  DATA_W  read data, registered.
o_start  out  1  single-cycle start pulse to the datapath.
i_done  in  1  datapath completion; valid only while o_busy is high.
i_busr  in  DATA_W  datapath result; sampled when i_done is high.
i_carry  in  1  datapath carry-out; sampled when i_done is high.
o_ops  out  NUM_OPS*DATA_W  operand registers, concatenated; op0 is in the LSBs.
o_busy  out  1  an operation is in flight.
o_irq  out  1  level interrupt, equal to DONE AND IRQ_EN.

Behaviour:
- Reset is the only reset mechanism. ARST high at a rising edge clears every register, o_data_rc, o_start, o_busy and o_irq to 0. This applies mid-operation as well: an in-flight operation is abandoned.
- Register map (word index):
  - 0 = CTRL: bit0 START (write-1 pulse, always reads 0), bit1 IRQ_EN (read/write).
  - 1 = STATUS: bit0 BUSY (read-only), bit1 DONE (write-1-to-clear), bit2 CARRY (write-1-to-clear), bit3 ERR (write-1-to-clear).
  - 2 = RESULT (read-only).
  - 3 .. 3+NUM_OPS-1 = OP0..OP(N-1) (read/write).
  - Unused bits read 0.
- Writes:
  - Take effect on the edge where i_en_amba_write=1.
  - For read/write registers, only bytes whose strobe bit is 1 are updated.
  - START, IRQ_EN and the W1C bits act only if strobe[0]=1.
  - Writes to read-only or unmapped indices are silently dropped.
- Reads:
  - o_data_rc is updated every cycle from i_addr_rc, so latency is 1 cycle.
  - Unmapped indices return 0.
  - A read in the same cycle as a write to the same index returns the pre-write value.
- Two states, IDLE and BUSY:
  - IDLE -> BUSY: a START write while in IDLE. On the next edge o_start=1 for exactly one cycle, BUSY=1, and DONE, CARRY and ERR are cleared.
  - BUSY -> IDLE: i_done=1. RESULT<=i_busr, CARRY<=i_carry, DONE<=1 and BUSY<=0 on that edge.
  - i_done while IDLE is ignored.
- Errors while BUSY:
  - A START write is ignored and sets ERR.
  - An operand write is dropped (operands are frozen) and sets ERR.
- Simultaneous events:
  - i_done in the same cycle as a W1C of DONE/CARRY: the set wins.
  - i_done in the same cycle as a START write: the START counts as issued in BUSY, so it is ignored and sets ERR.
  - A START write together with a W1C of ERR in IDLE: start proceeds and ERR ends 0.
- o_irq is combinational from registered DONE and IRQ_EN.
- Result width: RESULT is exactly DATA_W bits. The carry is reported only through CARRY.

Test Plan:
1. Reset: assert ARST for 2 cycles with writes active -> all outputs 0, and reads of indices 0..4 return 0.
2. Basic operation:
   - Stimulus: write OP0=0x0000_0005 and OP1=0x0000_0003, then CTRL=0x1; model i_done 3 cycles after o_start with i_busr=0x8 and i_carry=0.
   - Required: o_start high for 1 cycle, o_busy high until the done edge, RESULT reads 0x8, STATUS reads 0x2.
3. Strobes: OP0=0xFFFF_FFFF, then write 0x1234_5678 with strb=4'b0101 -> OP0 reads 0xFF34_FF78.
4. Busy protection: during BUSY write OP1=0xDEAD and CTRL=0x1 -> OP1 unchanged, no second o_start, STATUS bit3=1; W1C 0x8 clears ERR.
5. IRQ and carry:
   - Stimulus: set IRQ_EN, run an op with i_busr=0x0 and i_carry=1.
   - Required: o_irq=1, STATUS=0x6. Write STATUS=0x2 -> o_irq=0 while CARRY is still 1.
6. Reset mid-operation and collision:
   - ARST while BUSY -> o_busy=0; a later i_done is ignored and RESULT stays 0.
   - i_done in the same cycle as a W1C of DONE -> DONE=1.
